// File: rtl/synth_voice_allocator.sv
// Voice allocator: 2 channels x 3 slots with LRU stealing, strobed glitch-free note word.
// Optional StealCount output enabled by defining SYNTH_ALLOC_STEAL_CNT_EN.
module synth_voice_allocator #(
    parameter int unsigned SAMPLE_DIV = 1134,
    parameter logic [3:0]  IDLE_NOTE  = 4'd0
) (
    input  logic        MasterCLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqOn,
    input  logic        ReqChan,
    input  logic [3:0]  ReqNote,
    output logic [23:0] NoteWord,
    output logic [5:0]  VoiceActive,
    output logic        DataStrobe
`ifdef SYNTH_ALLOC_STEAL_CNT_EN
    ,
    output logic [7:0]  StealCount
`endif
);

    localparam int unsigned      CntW    = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {StIdle, StScan0, StScan1, StScan2, StCommit} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;

    logic [3:0] note_q   [2][3];
    logic       active_q [2][3];
    logic [1:0] rank_q   [2][3];

    logic       req_on_q, req_chan_q;
    logic [3:0] req_note_q;
    logic       free_found_q, match_found_q;
    logic [1:0] free_idx_q, match_idx_q, victim_idx_q;

    logic       scan_en;
    logic [1:0] scan_idx;
    logic [3:0] sel_note;
    logic       sel_active;
    logic [1:0] sel_rank;
    logic [1:0] cur_rank [3];

    logic       wr_en, wr_active, pr_en;
    logic [1:0] wr_idx, pr_idx, pr_old;
    logic [3:0] wr_note;

    logic [23:0] shadow_word;
    logic [5:0]  shadow_act;

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign DataStrobe = (cnt_q == CntLast);

    always_ff @(posedge MasterCLK) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ReqReady = 1'b0;
        scan_en  = 1'b0;
        scan_idx = 2'd0;
        unique case (state_q)
            StIdle: begin
                ReqReady = 1'b1;
                if (ReqValid) state_d = StScan0;
            end
            StScan0: begin
                scan_en  = 1'b1;
                scan_idx = 2'd0;
                state_d  = StScan1;
            end
            StScan1: begin
                scan_en  = 1'b1;
                scan_idx = 2'd1;
                state_d  = StScan2;
            end
            StScan2: begin
                scan_en  = 1'b1;
                scan_idx = 2'd2;
                state_d  = StCommit;
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Views of the latched channel's slots: the one under scan and all ranks.
    always_comb begin
        sel_note   = IDLE_NOTE;
        sel_active = 1'b0;
        sel_rank   = 2'd0;
        for (int s = 0; s < 3; s++) begin
            cur_rank[s] = rank_q[req_chan_q][s];
            if (2'(s) == scan_idx) begin
                sel_note   = note_q[req_chan_q][s];
                sel_active = active_q[req_chan_q][s];
                sel_rank   = rank_q[req_chan_q][s];
            end
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = 2'd0;
        wr_note   = IDLE_NOTE;
        wr_active = 1'b0;
        pr_en     = 1'b0;
        pr_idx    = 2'd0;
        if (req_on_q) begin
            pr_en = 1'b1;
            if (match_found_q) begin
                pr_idx = match_idx_q;
            end else begin
                wr_en     = 1'b1;
                wr_idx    = free_found_q ? free_idx_q : victim_idx_q;
                wr_note   = req_note_q;
                wr_active = 1'b1;
                pr_idx    = wr_idx;
            end
        end else if (match_found_q) begin
            wr_en  = 1'b1;
            wr_idx = match_idx_q;
        end
        pr_old = 2'd0;
        for (int s = 0; s < 3; s++) begin
            if (2'(s) == pr_idx) pr_old = cur_rank[s];
        end
    end

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s < 3; s++) begin
                    note_q[c][s]   <= IDLE_NOTE;
                    active_q[c][s] <= 1'b0;
                    rank_q[c][s]   <= 2'(s);
                end
            end
            req_on_q      <= 1'b0;
            req_chan_q    <= 1'b0;
            req_note_q    <= 4'd0;
            free_found_q  <= 1'b0;
            match_found_q <= 1'b0;
            free_idx_q    <= 2'd0;
            match_idx_q   <= 2'd0;
            victim_idx_q  <= 2'd0;
        end else begin
            if (ReqReady && ReqValid) begin
                req_on_q      <= ReqOn;
                req_chan_q    <= ReqChan;
                req_note_q    <= ReqNote;
                free_found_q  <= 1'b0;
                match_found_q <= 1'b0;
            end
            if (scan_en) begin
                if (!sel_active && !free_found_q) begin
                    free_found_q <= 1'b1;
                    free_idx_q   <= scan_idx;
                end
                if (sel_active && sel_note == req_note_q && !match_found_q) begin
                    match_found_q <= 1'b1;
                    match_idx_q   <= scan_idx;
                end
                if (sel_rank == 2'd0) victim_idx_q <= scan_idx;
            end
            if (state_q == StCommit) begin
                for (int s = 0; s < 3; s++) begin
                    if (wr_en && 2'(s) == wr_idx) begin
                        note_q[req_chan_q][s]   <= wr_note;
                        active_q[req_chan_q][s] <= wr_active;
                    end
                    if (pr_en) begin
                        if (2'(s) == pr_idx) rank_q[req_chan_q][s] <= 2'd2;
                        else if (cur_rank[s] > pr_old) rank_q[req_chan_q][s] <= cur_rank[s] - 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        shadow_word = '0;
        shadow_act  = '0;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) begin
                shadow_word[23-12*c-4*s -: 4] = note_q[c][s];
                shadow_act[5-3*c-s]           = active_q[c][s];
            end
        end
    end

    // Loading at the strobe edge takes pre-commit slot values when COMMIT coincides.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            NoteWord    <= {6{IDLE_NOTE}};
            VoiceActive <= '0;
        end else if (DataStrobe) begin
            NoteWord    <= shadow_word;
            VoiceActive <= shadow_act;
        end
    end

`ifdef SYNTH_ALLOC_STEAL_CNT_EN
    logic steal;
    assign steal = req_on_q && !match_found_q && !free_found_q;

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            StealCount <= 8'd0;
        end else if (state_q == StCommit && steal && StealCount != 8'hFF) begin
            StealCount <= StealCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_synth_voice_allocator.sv
// Bench for synth_voice_allocator: directed vector table, hand-built corner sequences,
// and random traffic checked every cycle against a timestamp-LRU reference model.
module tb_synth_voice_allocator;

    localparam int         Div  = 8;
    localparam logic [3:0] Idle = 4'd0;

    logic        MasterCLK = 1'b0;
    logic        Reset     = 1'b1;
    logic        ReqValid  = 1'b0;
    logic        ReqOn     = 1'b0;
    logic        ReqChan   = 1'b0;
    logic [3:0]  ReqNote   = 4'd0;
    logic        ReqReady;
    logic [23:0] NoteWord;
    logic [5:0]  VoiceActive;
    logic        DataStrobe;
`ifdef SYNTH_ALLOC_STEAL_CNT_EN
    logic [7:0]  StealCount;
`endif

    always #5 MasterCLK = ~MasterCLK;

    synth_voice_allocator #(
        .SAMPLE_DIV (Div),
        .IDLE_NOTE  (Idle)
    ) dut (
        .MasterCLK   (MasterCLK),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqOn       (ReqOn),
        .ReqChan     (ReqChan),
        .ReqNote     (ReqNote),
        .NoteWord    (NoteWord),
        .VoiceActive (VoiceActive),
        .DataStrobe  (DataStrobe)
`ifdef SYNTH_ALLOC_STEAL_CNT_EN
        ,
        .StealCount  (StealCount)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: slot contents plus allocation timestamps (oldest stamp = LRU).
    logic [3:0]  m_note [2][3];
    logic        m_act  [2][3];
    int          stamp  [2][3];
    int          gstamp;
    int          cyc;
    int          phase;
    bit          mvalid = 0;
    logic        l_on, l_chan;
    logic [3:0]  l_note;
    logic [23:0] exp_word;
    logic [5:0]  exp_act;
    int          exp_steal;

    typedef struct {
        logic        on;
        logic        chan;
        logic [3:0]  note;
        logic [23:0] word;
        logic [5:0]  act;
        int          steal;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) begin
                m_note[c][s] = Idle;
                m_act[c][s]  = 1'b0;
                stamp[c][s]  = s - 3;
            end
        end
        gstamp    = 0;
        cyc       = 0;
        phase     = 0;
        exp_word  = {6{Idle}};
        exp_act   = 6'd0;
        exp_steal = 0;
    endtask

    function automatic logic [23:0] m_word();
        logic [23:0] w;
        w = '0;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 3; s++) w[23-12*c-4*s -: 4] = m_note[c][s];
        return w;
    endfunction

    function automatic logic [5:0] m_vact();
        logic [5:0] v;
        v = '0;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 3; s++) v[5-3*c-s] = m_act[c][s];
        return v;
    endfunction

    task automatic promote(input int c, input int s);
        gstamp++;
        stamp[c][s] = gstamp;
    endtask

    task automatic model_commit();
        int c, match, free, v;
        c     = int'(l_chan);
        match = -1;
        free  = -1;
        for (int s = 0; s < 3; s++) begin
            if (m_act[c][s] && m_note[c][s] == l_note && match < 0) match = s;
            if (!m_act[c][s] && free < 0) free = s;
        end
        if (l_on) begin
            if (match >= 0) begin
                promote(c, match);
            end else begin
                if (free >= 0) begin
                    v = free;
                end else begin
                    v = 0;
                    for (int s = 1; s < 3; s++) if (stamp[c][s] < stamp[c][v]) v = s;
                    if (exp_steal < 255) exp_steal++;
                end
                m_note[c][v] = l_note;
                m_act[c][v]  = 1'b1;
                promote(c, v);
            end
        end else if (match >= 0) begin
            m_note[c][match] = Idle;
            m_act[c][match]  = 1'b0;
        end
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic tick();
        logic        strobe;
        logic [23:0] w;
        logic [5:0]  a;
        if (mvalid) begin
            chk("strobe", DataStrobe, (cyc % Div) == Div - 1);
            chk("ready", ReqReady, phase == 0);
            chk("note_word", NoteWord, exp_word);
            chk("voice_active", VoiceActive, exp_act);
`ifdef SYNTH_ALLOC_STEAL_CNT_EN
            chk("steal_count", StealCount, exp_steal);
`endif
        end
        if (Reset) begin
            model_reset();
        end else if (mvalid) begin
            strobe = (cyc % Div) == Div - 1;
            w = m_word();
            a = m_vact();
            if (phase == 0) begin
                if (ReqValid) begin
                    l_on   = ReqOn;
                    l_chan = ReqChan;
                    l_note = ReqNote;
                    phase  = 1;
                end
            end else if (phase < 4) begin
                phase++;
            end else begin
                model_commit();
                phase = 0;
            end
            if (strobe) begin
                exp_word = w;
                exp_act  = a;
            end
            cyc++;
        end
        @(posedge MasterCLK);
        #1;
        if (Reset) mvalid = 1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic issue(input logic on, input logic chan, input logic [3:0] note);
        int k = 0;
        while (!ReqReady && k < 10) begin
            tick();
            k++;
        end
        chk("ready_wait", ReqReady, 1'b1);
        ReqValid = 1'b1;
        ReqOn    = on;
        ReqChan  = chan;
        ReqNote  = note;
        tick();
        ReqValid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_update();
        int k = 0;
        while (!DataStrobe && k < 2 * Div) begin
            tick();
            k++;
        end
        chk("strobe_wait", DataStrobe, 1'b1);
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'd3,  24'h300000, 6'b100000, 0};
        vecs[1] = '{1'b1, 1'b0, 4'd5,  24'h350000, 6'b110000, 0};
        vecs[2] = '{1'b1, 1'b0, 4'd7,  24'h357000, 6'b111000, 0};
        vecs[3] = '{1'b1, 1'b0, 4'd9,  24'h957000, 6'b111000, 1};
        vecs[4] = '{1'b0, 1'b0, 4'd5,  24'h907000, 6'b101000, 1};
        vecs[5] = '{1'b0, 1'b0, 4'd12, 24'h907000, 6'b101000, 1};
        vecs[6] = '{1'b1, 1'b0, 4'd9,  24'h907000, 6'b101000, 1};
        vecs[7] = '{1'b1, 1'b0, 4'd4,  24'h947000, 6'b111000, 1};
        vecs[8] = '{1'b1, 1'b0, 4'd6,  24'h946000, 6'b111000, 2};
        vecs[9] = '{1'b1, 1'b1, 4'd10, 24'h946A00, 6'b111100, 2};

        // Reset values and strobe cadence.
        do_reset();
        chk("rst_ready", ReqReady, 1'b1);
        chk("rst_word", NoteWord, 24'h000000);
        chk("rst_active", VoiceActive, 6'd0);
        chk("rst_strobe", DataStrobe, 1'b0);
        repeat (7) tick();
        chk("strobe_7", DataStrobe, 1'b1);
        repeat (8) tick();
        chk("strobe_15", DataStrobe, 1'b1);
        repeat (8) tick();
        chk("strobe_23", DataStrobe, 1'b1);
        chk("idle_word", NoteWord, 24'h000000);

        // Directed allocation / steal / note-off / match sequence.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].on, vecs[i].chan, vecs[i].note);
            wait_update();
            chk($sformatf("vec%0d_word", i), NoteWord, vecs[i].word);
            chk($sformatf("vec%0d_active", i), VoiceActive, vecs[i].act);
`ifdef SYNTH_ALLOC_STEAL_CNT_EN
            chk($sformatf("vec%0d_steal", i), StealCount, vecs[i].steal);
`endif
        end

        // COMMIT coinciding with a strobe: accept at cycle 3, commit at cycle 7.
        do_reset();
        repeat (3) tick();
        ReqValid = 1'b1;
        ReqOn    = 1'b1;
        ReqChan  = 1'b1;
        ReqNote  = 4'd2;
        tick();
        ReqValid = 1'b0;
        repeat (4) tick();
        chk("coincide_hold", NoteWord, 24'h000000);
        repeat (8) tick();
        chk("coincide_next_word", NoteWord, 24'h000200);
        chk("coincide_next_active", VoiceActive, 6'b000100);

        // Reset while in SCAN1 discards the request.
        issue(1'b1, 1'b0, 4'd11);
        wait_update();
        ReqValid = 1'b1;
        ReqOn    = 1'b1;
        ReqChan  = 1'b0;
        ReqNote  = 4'd13;
        tick();
        ReqValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_ready", ReqReady, 1'b1);
        chk("abort_word", NoteWord, 24'h000000);
        chk("abort_active", VoiceActive, 6'd0);
        chk("abort_strobe", DataStrobe, 1'b0);
        repeat (7) tick();
        chk("abort_strobe_restart", DataStrobe, 1'b1);
        tick();
        chk("abort_discarded", VoiceActive, 6'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            ReqValid = ($urandom_range(0, 2) != 0);
            ReqOn    = ($urandom_range(0, 3) != 0);
            ReqChan  = 1'($urandom_range(0, 1));
            ReqNote  = 4'($urandom_range(0, 7));
            tick();
        end
        ReqValid = 1'b0;
        repeat (2 * Div) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
